// File: rtl/key_packetizer_pkg.sv
// Shared definitions for the key packetizer and the downstream buffer router.
// Contents: FSM state encoding, packet width, buffer-select field position,
// and the bit values that each push-button contributes to a packet.
package key_packetizer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int PKT_W   = 4;

    // Buffer select field of a packet; the remaining low bits are payload.
    localparam int SEL_MSB = 3;
    localparam int SEL_LSB = 2;

    // key1 contributes a '1', key2 contributes a '0'.
    localparam logic BIT_ONE  = 1'b1;
    localparam logic BIT_ZERO = 1'b0;

endpackage

// File: rtl/key_debounce.sv
// Input conditioning for one raw push-button.
// A 2-flop synchroniser feeds a debounce counter; the debounced level flips
// only after DEBOUNCE_CYCLES consecutive synced samples disagree with it.
// A one-cycle press pulse marks each debounced 0->1 transition.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   key   in  raw asynchronous button, active-high pressed
//   press out one-cycle pulse on a debounced press
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 2);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] arm_cnt;
    logic             armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            arm_cnt <= '0;
            armed   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
            press  <= 1'b0;

            if (sync_b != level) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync_b;
                    cnt   <= '0;
                    press <= sync_b & armed;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end

            // A button held through reset must not produce a press. Events
            // are enabled only once the button has been seen released for
            // DEBOUNCE_CYCLES+2 samples; the extra two cover the cleared
            // synchroniser flops, which would otherwise read as "released".
            if (!armed) begin
                if (!level && !sync_b) begin
                    if (arm_cnt == CNT_W'(DEBOUNCE_CYCLES + 1)) begin
                        armed <= 1'b1;
                    end else begin
                        arm_cnt <= arm_cnt + CNT_W'(1);
                    end
                end else begin
                    arm_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/key_packetizer.sv
// Turns two push-buttons into 4-bit packets, shifted in MSB-first, and
// presents each completed packet on a valid/ready handshake.
// Packet layout: [3:2] destination buffer select, [1:0] payload.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   key1      in  raw button, press = bit 1
//   key2      in  raw button, press = bit 0
//   pkt_ready in  downstream accepts when pkt_valid && pkt_ready
//   pkt_data  out assembled packet, first press in bit 3, unwritten bits 0
//   pkt_valid out packet complete and stable
//   bit_cnt   out bits collected so far (0..4)
//   drop      out one-cycle pulse when a press is discarded
//   timeout   out one-cycle pulse when a partial packet is abandoned
module key_packetizer
    import key_packetizer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int PKT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key1,
    input  logic             key2,
    input  logic             pkt_ready,
    output logic [PKT_W-1:0] pkt_data,
    output logic             pkt_valid,
    output logic [2:0]       bit_cnt,
    output logic             drop,
    output logic             timeout
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W = $clog2(PKT_W);

    logic press1;
    logic press2;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_key1 (
        .clk   (clk),
        .rst   (rst),
        .key   (key1),
        .press (press1)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_key2 (
        .clk   (clk),
        .rst   (rst),
        .key   (key2),
        .press (press2)
    );

    state_t            state;
    state_t            state_nxt;
    logic [PKT_W-1:0]  data_nxt;
    logic [2:0]        cnt_nxt;
    logic              valid_nxt;
    logic              drop_nxt;
    logic              timeout_nxt;
    logic [TO_W-1:0]   idle_cnt;
    logic [TO_W-1:0]   idle_nxt;

    logic              both;
    logic              single;
    logic              new_bit;
    logic [IDX_W-1:0]  wr_idx;

    always_comb begin
        both    = press1 & press2;
        single  = press1 ^ press2;
        new_bit = press1 ? BIT_ONE : BIT_ZERO;
        // Bits fill from the MSB down; in IDLE bit_cnt is 0 so this is bit 3.
        wr_idx  = IDX_W'(PKT_W - 1) - bit_cnt[IDX_W-1:0];

        state_nxt   = state;
        data_nxt    = pkt_data;
        cnt_nxt     = bit_cnt;
        valid_nxt   = pkt_valid;
        drop_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        idle_nxt    = idle_cnt;

        case (state)
            IDLE: begin
                if (both) begin
                    drop_nxt = 1'b1;
                end else if (single) begin
                    data_nxt[wr_idx] = new_bit;
                    cnt_nxt          = 3'd1;
                    idle_nxt         = '0;
                    state_nxt        = COLLECT;
                end
            end

            COLLECT: begin
                // A single event in the expiry cycle takes priority over
                // the timeout; a simultaneous (dropped) pair does not.
                if (single) begin
                    data_nxt[wr_idx] = new_bit;
                    cnt_nxt          = bit_cnt + 3'd1;
                    idle_nxt         = '0;
                    if (bit_cnt == 3'(PKT_W - 1)) begin
                        state_nxt = HOLD;
                        valid_nxt = 1'b1;
                    end
                end else begin
                    drop_nxt = both;
                    if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_nxt = 1'b1;
                        data_nxt    = '0;
                        cnt_nxt     = 3'd0;
                        idle_nxt    = '0;
                        state_nxt   = IDLE;
                    end else begin
                        idle_nxt = idle_cnt + TO_W'(1);
                    end
                end
            end

            HOLD: begin
                // Presses while a packet waits are never carried over,
                // including one landing in the acceptance cycle.
                drop_nxt = press1 | press2;
                if (pkt_valid && pkt_ready) begin
                    valid_nxt = 1'b0;
                    data_nxt  = '0;
                    cnt_nxt   = 3'd0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                data_nxt  = '0;
                cnt_nxt   = 3'd0;
                valid_nxt = 1'b0;
                idle_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
            bit_cnt   <= 3'd0;
            drop      <= 1'b0;
            timeout   <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            pkt_data  <= data_nxt;
            pkt_valid <= valid_nxt;
            bit_cnt   <= cnt_nxt;
            drop      <= drop_nxt;
            timeout   <= timeout_nxt;
            idle_cnt  <= idle_nxt;
        end
    end

endmodule

// File: tb/tb_key_packetizer.sv
// Testbench for key_packetizer with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_key_packetizer;
    import key_packetizer_pkg::*;

    localparam int DEB = 4;
    localparam int TMO = 64;
    // Raw press stable before edge 0 -> event pulse after edge DEB+1
    // (2 + DEB cycles) -> packetizer reacts at edge DEB+2.
    localparam int LAT = DEB + 2;

    logic       clk;
    logic       rst;
    logic       key1;
    logic       key2;
    logic       pkt_ready;
    logic [3:0] pkt_data;
    logic       pkt_valid;
    logic [2:0] bit_cnt;
    logic       drop;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int drop_cnt = 0;
    int to_cnt = 0;

    key_packetizer #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO),
        .PKT_W          (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key1     (key1),
        .key2     (key2),
        .pkt_ready(pkt_ready),
        .pkt_data (pkt_data),
        .pkt_valid(pkt_valid),
        .bit_cnt  (bit_cnt),
        .drop     (drop),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally, sampled away from the active edge.
    always @(negedge clk) begin
        if (drop)    drop_cnt = drop_cnt + 1;
        if (timeout) to_cnt   = to_cnt + 1;
    end

    // Reference: packet is the press sequence MSB-first, unwritten bits 0.
    function automatic logic [3:0] pack(input bit q[$]);
        logic [3:0] w;
        w = 4'b0000;
        for (int i = 0; i < q.size() && i < 4; i++) w[3-i] = q[i];
        return w;
    endfunction

    task automatic set_keys(input int k, input logic v);
        if (k == 1 || k == 2) key1 = v;
        if (k == 0 || k == 2) key2 = v;
    endtask

    // k: 1 = key1, 0 = key2, 2 = both in the same raw cycle.
    task automatic press(input int k, input int hold, input int gap);
        @(negedge clk);
        set_keys(k, 1'b1);
        repeat (hold) @(negedge clk);
        set_keys(k, 1'b0);
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; key1 = 1'b0; key2 = 1'b0; pkt_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (pkt_data !== 4'd0) begin n_bad++; $display("FAIL reset_data: got %b want 0000", pkt_data); end
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", pkt_valid); end
        n_cmp++; if (bit_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bit_cnt); end
        n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got %b want 0", drop); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_bouncy();
        int d0;
        do_reset();
        d0 = drop_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            key1 = (i % 2 == 0);
        end
        @(negedge clk);
        key1 = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            if (e == LAT - 1) begin
                n_cmp++; if (bit_cnt !== 3'd0) begin n_bad++; $display("FAIL bouncy_early: edge %0d got %0d want 0", e, bit_cnt); end
            end
            if (e == LAT) begin
                n_cmp++; if (bit_cnt !== 3'd1) begin n_bad++; $display("FAIL bouncy_event: edge %0d got %0d want 1", e, bit_cnt); end
            end
        end
        key1 = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++; if (bit_cnt !== 3'd1) begin n_bad++; $display("FAIL bouncy_once: got %0d want 1", bit_cnt); end
        n_cmp++; if (pkt_data !== 4'b1000) begin n_bad++; $display("FAIL bouncy_data: got %b want 1000", pkt_data); end
        n_cmp++; if (drop_cnt != d0) begin n_bad++; $display("FAIL bouncy_drop: got %0d want 0", drop_cnt - d0); end
    endtask

    task automatic test_handshake();
        int bad;
        do_reset();
        press(1, 8, 12); press(0, 8, 12); press(1, 8, 12); press(1, 8, 12);
        n_cmp++; if (pkt_valid !== 1'b1) begin n_bad++; $display("FAIL hs_valid: got %b want 1", pkt_valid); end
        n_cmp++; if (pkt_data !== 4'b1011) begin n_bad++; $display("FAIL hs_data: got %b want 1011", pkt_data); end
        n_cmp++; if (pkt_data[SEL_MSB:SEL_LSB] !== 2'b10) begin n_bad++; $display("FAIL hs_sel: got %b want 10", pkt_data[SEL_MSB:SEL_LSB]); end
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (pkt_valid !== 1'b1 || pkt_data !== 4'b1011 || bit_cnt !== 3'd4) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hs_hold: %0d unstable cycles, want 0", bad); end
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL hs_accept_valid: got %b want 0", pkt_valid); end
        n_cmp++; if (bit_cnt !== 3'd0) begin n_bad++; $display("FAIL hs_accept_cnt: got %0d want 0", bit_cnt); end
        n_cmp++; if (pkt_data !== 4'd0) begin n_bad++; $display("FAIL hs_accept_data: got %b want 0000", pkt_data); end
    endtask

    task automatic test_blocked();
        int d0;
        do_reset();
        press(0, 8, 12); press(1, 8, 12); press(1, 8, 12); press(0, 8, 12);
        n_cmp++; if (pkt_data !== 4'b0110) begin n_bad++; $display("FAIL blk_data: got %b want 0110", pkt_data); end
        d0 = drop_cnt;
        press(0, 8, 12);
        n_cmp++; if (drop_cnt - d0 != 1) begin n_bad++; $display("FAIL blk_drop: got %0d pulses want 1", drop_cnt - d0); end
        n_cmp++; if (pkt_data !== 4'b0110 || pkt_valid !== 1'b1) begin n_bad++; $display("FAIL blk_keep: got %b/%b want 0110/1", pkt_data, pkt_valid); end
        // Press timed to reach the packetizer exactly in the acceptance cycle.
        @(negedge clk);
        key2 = 1'b1;
        repeat (LAT) @(negedge clk);
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        n_cmp++; if (drop !== 1'b1) begin n_bad++; $display("FAIL blk_accept_drop: got %b want 1", drop); end
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL blk_accept_valid: got %b want 0", pkt_valid); end
        key2 = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++; if (bit_cnt !== 3'd0) begin n_bad++; $display("FAIL blk_no_carry: got %0d want 0", bit_cnt); end
    endtask

    task automatic test_simultaneous();
        int d0;
        do_reset();
        press(1, 8, 12);
        d0 = drop_cnt;
        press(2, 8, 12);
        n_cmp++; if (drop_cnt - d0 != 1) begin n_bad++; $display("FAIL simul_drop: got %0d pulses want 1", drop_cnt - d0); end
        n_cmp++; if (bit_cnt !== 3'd1) begin n_bad++; $display("FAIL simul_cnt: got %0d want 1", bit_cnt); end
        n_cmp++; if (pkt_data !== 4'b1000) begin n_bad++; $display("FAIL simul_data: got %b want 1000", pkt_data); end
    endtask

    task automatic test_timeout();
        int ev_e;
        int to_e;
        int t0;
        do_reset();
        press(0, 8, 12);
        t0 = to_cnt;
        ev_e = -1;
        to_e = -1;
        @(negedge clk);
        key1 = 1'b1;
        for (int e = 0; e < 100; e++) begin
            @(negedge clk);
            if (e == 8) key1 = 1'b0;
            if (bit_cnt == 3'd2 && ev_e < 0) ev_e = e;
            if (timeout === 1'b1 && to_e < 0) to_e = e;
        end
        n_cmp++; if (ev_e < 0 || to_e < 0 || to_e - ev_e != TMO) begin n_bad++; $display("FAIL to_delay: got %0d (ev %0d to %0d) want %0d", to_e - ev_e, ev_e, to_e, TMO); end
        n_cmp++; if (to_cnt - t0 != 1) begin n_bad++; $display("FAIL to_pulses: got %0d want 1", to_cnt - t0); end
        n_cmp++; if (bit_cnt !== 3'd0 || pkt_data !== 4'd0) begin n_bad++; $display("FAIL to_clear: got %0d/%b want 0/0000", bit_cnt, pkt_data); end
        press(1, 8, 12);
        n_cmp++; if (pkt_data !== 4'b1000 || bit_cnt !== 3'd1) begin n_bad++; $display("FAIL to_restart: got %b/%0d want 1000/1", pkt_data, bit_cnt); end
    endtask

    task automatic test_reset_mid();
        int bad;
        int d0;
        do_reset();
        press(1, 8, 12); press(0, 8, 12); press(1, 8, 12);
        n_cmp++; if (bit_cnt !== 3'd3) begin n_bad++; $display("FAIL rmid_pre: got %0d want 3", bit_cnt); end
        @(negedge clk);
        key1 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bit_cnt !== 3'd0 || pkt_data !== 4'd0 || pkt_valid !== 1'b0 || drop !== 1'b0 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL rmid_outputs: got cnt=%0d data=%b v=%b d=%b t=%b want all 0", bit_cnt, pkt_data, pkt_valid, drop, timeout);
        end
        bad = 0;
        d0 = drop_cnt;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bit_cnt !== 3'd0) bad++;
        end
        n_cmp++; if (bad != 0 || drop_cnt != d0) begin n_bad++; $display("FAIL rmid_held: %0d cycles with bits, %0d drops, want 0/0", bad, drop_cnt - d0); end
        key1 = 1'b0;
        repeat (20) @(negedge clk);
        press(1, 8, 12);
        n_cmp++; if (bit_cnt !== 3'd1 || pkt_data !== 4'b1000) begin n_bad++; $display("FAIL rmid_repress: got %0d/%b want 1/1000", bit_cnt, pkt_data); end
    endtask

    task automatic test_random();
        bit q[$];
        int k;
        int d0;
        logic [3:0] exp_w;
        do_reset();
        for (int p = 0; p < 12; p++) begin
            q.delete();
            for (int i = 0; i < 4; i++) begin
                k = $urandom_range(0, 1);
                q.push_back(k[0]);
                press(k, $urandom_range(DEB, DEB + 6), $urandom_range(12, 18));
                exp_w = pack(q);
                n_cmp++; if (bit_cnt !== 3'(q.size()) || pkt_data !== exp_w) begin
                    n_bad++; $display("FAIL rnd_shift: pkt %0d got %0d/%b want %0d/%b", p, bit_cnt, pkt_data, q.size(), exp_w);
                end
            end
            exp_w = pack(q);
            n_cmp++; if (pkt_valid !== 1'b1) begin n_bad++; $display("FAIL rnd_valid: pkt %0d got %b want 1", p, pkt_valid); end
            if ($urandom_range(0, 1) == 1) begin
                d0 = drop_cnt;
                press($urandom_range(0, 2), 8, 12);
                n_cmp++; if (drop_cnt - d0 != 1 || pkt_data !== exp_w) begin
                    n_bad++; $display("FAIL rnd_hold_drop: pkt %0d got %0d drops %b want 1 drops %b", p, drop_cnt - d0, pkt_data, exp_w);
                end
            end
            repeat ($urandom_range(0, 8)) @(negedge clk);
            pkt_ready = 1'b1;
            @(negedge clk);
            pkt_ready = 1'b0;
            n_cmp++; if (pkt_valid !== 1'b0 || bit_cnt !== 3'd0) begin
                n_bad++; $display("FAIL rnd_accept: pkt %0d got v=%b cnt=%0d want 0/0", p, pkt_valid, bit_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bouncy();
        test_handshake();
        test_blocked();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
